// File: rtl/scan_sequencer.sv
// scan_sequencer: blank/dwell scan controller for a 3-to-8 decoder.
// Define SCAN_MASK_EN to add the ChannelMask skip input.
module scan_sequencer #(
  parameter int DWELL_CYCLES = 16,
  parameter int BLANK_CYCLES = 2,
  parameter int LAST_CHANNEL = 7
) (
  input  logic       Clock,
  input  logic       ResetB,
  input  logic       Run,
  input  logic       SingleFrame,
`ifdef SCAN_MASK_EN
  input  logic [7:0] ChannelMask,
`endif
  output logic       NumberBit0,
  output logic       NumberBit1,
  output logic       NumberBit2,
  output logic       EnableB0,
  output logic       EnableB1,
  output logic       Enable2,
  output logic       Busy,
  output logic       FrameDone
);

  typedef enum logic [1:0] {
    IDLE,
    BLANK,
    DWELL
  } state_t;

  localparam int MAXC =
    (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    chan;
  logic          enB0;
  logic          enB1;
  logic          en2;
  logic          busyR;
  logic          doneR;

  logic [7:0]    maskBits;
  logic [7:0]    elig;
  logic [3:0]    firstPick;
  logic [3:0]    nextPick;

`ifdef SCAN_MASK_EN
  assign maskBits = ChannelMask;
`else
  assign maskBits = 8'h00;
`endif

  // Lowest eligible channel at or above 'from'; bit 3 flags a hit.
  function automatic logic [3:0] pick(
    input logic [7:0] e,
    input logic [3:0] from
  );
    logic [3:0] r;
    r = 4'h0;
    for (int i = 7; i >= 0; i--) begin
      if (e[i] && (i >= int'(from))) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  // Eligible channels and the candidate next selections.
  always_comb begin
    elig = 8'h00;
    for (int i = 0; i < 8; i++) begin
      elig[i] = (i <= LAST_CHANNEL) && !maskBits[i];
    end
    firstPick = pick(elig, 4'd0);
    nextPick  = pick(elig, {1'b0, chan} + 4'd1);
  end

  // Scan FSM with registered select, enable and status outputs.
  always_ff @(posedge Clock or negedge ResetB) begin
    if (!ResetB) begin
      state <= IDLE;
      cnt   <= '0;
      chan  <= 3'd0;
      enB0  <= 1'b1;
      enB1  <= 1'b1;
      en2   <= 1'b0;
      busyR <= 1'b0;
      doneR <= 1'b0;
    end else begin
      doneR <= 1'b0;
      case (state)
        IDLE: begin
          if (Run && firstPick[3]) begin
            state <= BLANK;
            chan  <= firstPick[2:0];
            cnt   <= '0;
            busyR <= 1'b1;
          end
        end
        BLANK: begin
          if (!Run) begin
            state <= IDLE;
            cnt   <= '0;
            busyR <= 1'b0;
          end else if (cnt == BLANK_LAST) begin
            state <= DWELL;
            cnt   <= '0;
            enB0  <= 1'b0;
            enB1  <= 1'b0;
            en2   <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DWELL: begin
          if (cnt == DWELL_LAST) begin
            cnt  <= '0;
            enB0 <= 1'b1;
            enB1 <= 1'b1;
            en2  <= 1'b0;
            if (nextPick[3]) begin
              if (Run) begin
                state <= BLANK;
                chan  <= nextPick[2:0];
              end else begin
                state <= IDLE;
                busyR <= 1'b0;
              end
            end else begin
              // Frame completed on this edge.
              doneR <= 1'b1;
              if (SingleFrame || !Run || !firstPick[3]) begin
                state <= IDLE;
                busyR <= 1'b0;
              end else begin
                state <= BLANK;
                chan  <= firstPick[2:0];
              end
            end
          end else if (!Run) begin
            state <= IDLE;
            cnt   <= '0;
            enB0  <= 1'b1;
            enB1  <= 1'b1;
            en2   <= 1'b0;
            busyR <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busyR <= 1'b0;
        end
      endcase
    end
  end

  assign NumberBit0 = chan[0];
  assign NumberBit1 = chan[1];
  assign NumberBit2 = chan[2];
  assign EnableB0   = enB0;
  assign EnableB1   = enB1;
  assign Enable2    = en2;
  assign Busy       = busyR;
  assign FrameDone  = doneR;

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: scoreboard bench for scan_sequencer.
// Random run/abort segments, single frame and async reset.
module tb_scan_sequencer;

  localparam int DW  = 16;
  localparam int BL  = 2;
  localparam int LC  = 7;
  localparam int PER = DW + BL;

  typedef struct {
    bit isFrame;
    int ch;
    int len;
  } ev_t;

  logic clk = 1'b0;
  logic rstB = 1'b0;
  logic run = 1'b0;
  logic sf = 1'b0;
  logic [7:0] mask = 8'h00;
  logic nb0, nb1, nb2, eb0, eb1, en2, busy, fd;

  ev_t q[$];
  int  errors = 0;
  int  checks = 0;
  int  chList[$];

  always #5 clk = ~clk;

  scan_sequencer #(
    .DWELL_CYCLES(DW),
    .BLANK_CYCLES(BL),
    .LAST_CHANNEL(LC)
  ) dut (
    .Clock(clk),
    .ResetB(rstB),
    .Run(run),
    .SingleFrame(sf),
`ifdef SCAN_MASK_EN
    .ChannelMask(mask),
`endif
    .NumberBit0(nb0),
    .NumberBit1(nb1),
    .NumberBit2(nb2),
    .EnableB0(eb0),
    .EnableB1(eb1),
    .Enable2(en2),
    .Busy(busy),
    .FrameDone(fd)
  );

  function automatic int sel();
    return int'({nb2, nb1, nb0});
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Channels scanned per frame, in order, from the mask.
  task automatic buildList();
    chList.delete();
    for (int c = 0; c <= LC; c++) if (!mask[c]) chList.push_back(c);
  endtask

  task automatic pushWin(input int c, input int len);
    ev_t e;
    e.isFrame = 1'b0;
    e.ch = c;
    e.len = len;
    q.push_back(e);
  endtask

  task automatic pushFrame(input int spacing);
    ev_t e;
    e.isFrame = 1'b1;
    e.ch = 0;
    e.len = spacing;
    q.push_back(e);
  endtask

  task automatic chkIdle(input string name, input int s);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_en2"}, int'(en2), 0);
    chk({name, "_enb"}, int'({eb1, eb0}), 3);
    chk({name, "_sel"}, sel(), s);
  endtask

  // Monitor: pops expected events as the DUT presents windows/frames.
  initial begin : monitor
    bit   prevEn2 = 0;
    int   prevSel = 0;
    int   winLen = 0;
    int   gapLen = 0;
    int   cyc = 0;
    int   lastFd = 0;
    ev_t  cur;
    ev_t  e;
    cur.isFrame = 0;
    cur.ch = 0;
    cur.len = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstB) begin
        prevEn2 = 0;
        winLen = 0;
        gapLen = 0;
      end else begin
        if (en2 && !prevEn2) begin
          if (q.size() == 0) begin
            chk("unexpected_window", 1, 0);
          end else begin
            cur = q.pop_front();
            chk("win_kind", int'(cur.isFrame), 0);
            chk("win_sel", sel(), cur.ch);
          end
          chk("blank_gap", gapLen, BL);
          winLen = 1;
        end else if (en2 && prevEn2) begin
          winLen++;
          if (sel() != prevSel) chk("sel_stable", sel(), prevSel);
        end else if (!en2 && prevEn2) begin
          chk("win_len", winLen, cur.len);
          gapLen = 0;
        end
        if (!en2 && busy) gapLen++;
        if (!busy) gapLen = 0;
        if (fd) begin
          if (q.size() == 0) begin
            chk("unexpected_framedone", 1, 0);
          end else begin
            e = q.pop_front();
            chk("fd_kind", int'(e.isFrame), 1);
            if (e.len != 0) chk("fd_spacing", cyc - lastFd, e.len);
          end
          lastFd = cyc;
        end
        prevEn2 = en2;
        prevSel = sel();
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int nf;
    int idx;
    int d;
    int t;
    int fp;
`ifdef SCAN_MASK_EN
    mask = 8'hA5;
`endif
    buildList();
    fp = chList.size() * PER;
    #12;
    chk("rst_fd", int'(fd), 0);
    chkIdle("rst", 0);
    @(negedge clk);
    rstB = 1'b1;

    // Random continuous runs, aborted mid-dwell.
    for (int s = 0; s < 4; s++) begin
      nf  = $urandom_range(0, 2);
      idx = $urandom_range(0, chList.size() - 1);
      d   = $urandom_range(0, DW - 2);
      for (int f = 0; f < nf; f++) begin
        foreach (chList[i]) pushWin(chList[i], DW);
        pushFrame(f == 0 ? 0 : fp);
      end
      for (int i = 0; i < idx; i++) pushWin(chList[i], DW);
      pushWin(chList[idx], d + 1);
      t = nf * fp + idx * PER + BL + d;
      @(negedge clk);
      sf  = 1'b0;
      run = 1'b1;
      @(posedge clk);
      #1;
      chk("start_busy", int'(busy), 1);
      chk("start_sel", sel(), chList[0]);
      repeat (t) @(posedge clk);
      @(negedge clk);
      if (nf > 0) chk("mid_busy", int'(busy), 1);
      run = 1'b0;
      @(negedge clk);
      chk("abort_fd", int'(fd), 0);
      chkIdle("abort", chList[idx]);
      repeat (6) @(negedge clk);
      chkIdle("abort_hold", chList[idx]);
      chk("abort_q_empty", q.size(), 0);
    end

    // Single frame: release Run in the FrameDone cycle.
    foreach (chList[i]) pushWin(chList[i], DW);
    pushFrame(0);
    @(negedge clk);
    sf  = 1'b1;
    run = 1'b1;
    repeat (fp + 1) @(posedge clk);
    @(negedge clk);
    chk("single_fd", int'(fd), 1);
    chkIdle("single_end", chList[chList.size() - 1]);
    run = 1'b0;
    sf  = 1'b0;
    repeat (4) @(negedge clk);
    chkIdle("single_idle", chList[chList.size() - 1]);
    chk("single_q_empty", q.size(), 0);

    // Async reset mid-dwell of the third scanned channel.
    for (int i = 0; i < 3; i++) pushWin(chList[i], DW);
    @(negedge clk);
    run = 1'b1;
    repeat (2 * PER + BL + 6) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_en2", int'(en2), 1);
    #2;
    rstB = 1'b0;
    #1;
    chk("arst_fd", int'(fd), 0);
    chkIdle("arst", 0);
    run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstB = 1'b1;
    chk("arst_q_empty", q.size(), 0);
    q.delete();

`ifdef SCAN_MASK_EN
    // Everything masked: never leaves IDLE.
    @(negedge clk);
    mask = 8'hFF;
    run  = 1'b1;
    repeat (10) @(negedge clk);
    chkIdle("all_masked", 0);
    run  = 1'b0;
    mask = 8'hA5;
`endif

    repeat (3) @(negedge clk);
    chk("final_q_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
